// File: rtl/chip8_draw_ctrl.sv
// CHIP-8 DXYN / CLS draw sequencer: fetches sprite rows and drives the display datapath.
// Optional macro CHIP8_DRAW_CLIP_EN: clip sprites at the right and bottom screen edges.
module chip8_draw_ctrl #(
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              cls,
    input  logic [7:0]        vx,
    input  logic [7:0]        vy,
    input  logic [3:0]        n,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_data,
    output logic              disp_draw,
    output logic              disp_clear,
    output logic [5:0]        disp_x,
    output logic [4:0]        disp_y,
    output logic [3:0]        disp_row,
    output logic [7:0]        disp_sprite,
    input  logic              disp_collision,
    output logic              busy,
    output logic              done,
    output logic              vf
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT,
        DRAW,
        COLL,
        CLEAR,
        DONE
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] base;
    logic [3:0]        rows;
    logic [3:0]        row;
    logic              acc;

    logic              acc_next;
    logic [3:0]        row_next;
    logic              last_row;
    logic [7:0]        sprite_in;
    logic              unused_bits;

    assign busy        = (state != IDLE);
    assign acc_next    = acc | disp_collision;
    assign row_next    = row + 4'd1;
    assign unused_bits = &{1'b0, vx[7:6], vy[7:5]};

`ifdef CHIP8_DRAW_CLIP_EN
    logic [6:0] y_next;

    // Bit 7 lands on disp_x; bits that would fall past column 63 are dropped.
    assign y_next    = {2'b00, disp_y} + {3'b000, row} + 7'd1;
    assign last_row  = (row == rows - 4'd1) || (y_next >= 7'd32);
    assign sprite_in = (disp_x > 6'd56)
                     ? (mem_data & (8'hFF << (disp_x - 6'd56)))
                     : mem_data;
`else
    assign last_row  = (row == rows - 4'd1);
    assign sprite_in = mem_data;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            base        <= '0;
            rows        <= '0;
            row         <= '0;
            acc         <= 1'b0;
            mem_rd      <= 1'b0;
            mem_addr    <= '0;
            disp_draw   <= 1'b0;
            disp_clear  <= 1'b0;
            disp_x      <= '0;
            disp_y      <= '0;
            disp_row    <= '0;
            disp_sprite <= '0;
            done        <= 1'b0;
            vf          <= 1'b0;
        end else begin
            mem_rd     <= 1'b0;
            disp_draw  <= 1'b0;
            disp_clear <= 1'b0;
            done       <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (cls) begin
                        disp_clear <= 1'b1;
                        state      <= CLEAR;
                    end else if (start) begin
                        disp_x <= vx[5:0];
                        disp_y <= vy[4:0];
                        base   <= i_addr;
                        rows   <= n;
                        row    <= '0;
                        acc    <= 1'b0;
                        if (n == 4'd0) begin
                            done  <= 1'b1;
                            vf    <= 1'b0;
                            state <= DONE;
                        end else begin
                            mem_rd   <= 1'b1;
                            mem_addr <= i_addr;
                            state    <= FETCH;
                        end
                    end
                end
                FETCH: state <= WAIT;
                WAIT: begin
                    disp_sprite <= sprite_in;
                    disp_row    <= row;
                    disp_draw   <= 1'b1;
                    state       <= DRAW;
                end
                DRAW: state <= COLL;
                COLL: begin
                    acc <= acc_next;
                    if (last_row) begin
                        done  <= 1'b1;
                        vf    <= acc_next;
                        state <= DONE;
                    end else begin
                        row      <= row_next;
                        mem_addr <= base + ADDR_W'(row_next);
                        mem_rd   <= 1'b1;
                        state    <= FETCH;
                    end
                end
                CLEAR: begin
                    acc   <= 1'b0;
                    done  <= 1'b1;
                    vf    <= 1'b0;
                    state <= DONE;
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_chip8_draw_ctrl.sv
// Directed bench for chip8_draw_ctrl with a sprite memory and XOR display model.
// Honours CHIP8_DRAW_CLIP_EN when picking expected values.
module tb_chip8_draw_ctrl;

`ifdef CHIP8_DRAW_CLIP_EN
    localparam bit CLIP = 1'b1;
`else
    localparam bit CLIP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset, start, cls;
    logic [7:0]  vx, vy;
    logic [3:0]  n;
    logic [11:0] i_addr;
    logic        mem_rd;
    logic [11:0] mem_addr;
    logic [7:0]  mem_data;
    logic        disp_draw, disp_clear;
    logic [5:0]  disp_x;
    logic [4:0]  disp_y;
    logic [3:0]  disp_row;
    logic [7:0]  disp_sprite;
    logic        disp_collision;
    logic        busy, done, vf;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    chip8_draw_ctrl #(.ADDR_W(12)) dut (
        .clk(clk), .reset(reset), .start(start), .cls(cls),
        .vx(vx), .vy(vy), .n(n), .i_addr(i_addr),
        .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_data(mem_data),
        .disp_draw(disp_draw), .disp_clear(disp_clear),
        .disp_x(disp_x), .disp_y(disp_y), .disp_row(disp_row),
        .disp_sprite(disp_sprite), .disp_collision(disp_collision),
        .busy(busy), .done(done), .vf(vf)
    );

    logic [7:0]  mem [4096];
    logic [63:0] fb [32];

    always @(posedge clk) if (mem_rd) mem_data <= mem[mem_addr];

    int   px, py;
    logic hit;
    always @(posedge clk) begin
        disp_collision <= 1'b0;
        if (disp_clear) for (int r = 0; r < 32; r++) fb[r] <= '0;
        if (disp_draw) begin
            hit = 1'b0;
            py  = (int'(disp_y) + int'(disp_row)) % 32;
            for (int i = 0; i < 8; i++) begin
                if (disp_sprite[7-i]) begin
                    px = (int'(disp_x) + i) % 64;
                    if (fb[py][px]) hit = 1'b1;
                    fb[py][px] <= ~fb[py][px];
                end
            end
            disp_collision <= hit;
        end
    end

    int          rd_cyc[$];
    logic [11:0] addrs[$];
    int          drw_cyc[$];
    logic [7:0]  sprs[$];
    logic [3:0]  rws[$];
    logic [5:0]  dxs[$];
    int          done_cyc, clr_cyc, busy_drop;
    logic        vf_done, zero_ok;

    task automatic run(input logic do_cls, input logic do_start,
                       input logic [7:0] x, input logic [7:0] y,
                       input logic [3:0] nn, input logic [11:0] ia,
                       input int abort_at, input logic hold_start);
        @(negedge clk);
        cls = do_cls; start = do_start;
        vx = x; vy = y; n = nn; i_addr = ia;
        @(posedge clk);
        #1;
        cls = 1'b0;
        if (!hold_start) start = 1'b0;
        vx = 8'hA5; vy = 8'h5A; n = 4'hF; i_addr = 12'h777;
        rd_cyc.delete(); addrs.delete(); drw_cyc.delete();
        sprs.delete(); rws.delete(); dxs.delete();
        done_cyc = -1; clr_cyc = -1; busy_drop = -1;
        vf_done = 1'bx; zero_ok = 1'b0;
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            if (c == 2) start = 1'b0;
            if (!busy) begin
                busy_drop = c;
                zero_ok = ({mem_rd, disp_draw, disp_clear, done, vf,
                            mem_addr, disp_x, disp_y, disp_row,
                            disp_sprite} == '0);
                break;
            end
            if (mem_rd) begin rd_cyc.push_back(c); addrs.push_back(mem_addr); end
            if (disp_draw) begin
                drw_cyc.push_back(c); sprs.push_back(disp_sprite);
                rws.push_back(disp_row); dxs.push_back(disp_x);
            end
            if (disp_clear) clr_cyc = c;
            if (done) begin done_cyc = c; vf_done = vf; end
            if (c == abort_at) reset = 1'b1;
        end
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; cls = 1'b0;
        vx = 8'hFF; vy = 8'hFF; n = 4'hF; i_addr = 12'hFFF;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_assert++;
        if ({busy, done, vf, mem_rd, disp_draw, disp_clear} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b expected 000000",
                     {busy, done, vf, mem_rd, disp_draw, disp_clear});
        end
        n_assert++;
        if ({mem_addr, disp_x, disp_y, disp_row, disp_sprite} !== 35'b0) begin
            n_fail++;
            $display("FAIL reset_operands: got %h expected 0",
                     {mem_addr, disp_x, disp_y, disp_row, disp_sprite});
        end
        reset = 1'b0;
        @(negedge clk);
        n_assert++;
        if (busy !== 1'b0) begin
            n_fail++; $display("FAIL reset_idle_busy: got %b expected 0", busy);
        end
    endtask

    task automatic test_basic_draw();
        run(1'b0, 1'b1, 8'd0, 8'd0, 4'd1, 12'h050, 0, 1'b0);
        n_assert++;
        if (rd_cyc.size() != 1 || rd_cyc[0] != 1 || addrs[0] !== 12'h050) begin
            n_fail++;
            $display("FAIL basic_fetch: got %0d reads, first addr %h, expected 1 read of 050 at cycle 1",
                     rd_cyc.size(), addrs.size() ? addrs[0] : 12'hxxx);
        end
        n_assert++;
        if (drw_cyc.size() != 1 || drw_cyc[0] != 3 || sprs[0] !== 8'hF0) begin
            n_fail++;
            $display("FAIL basic_draw: got %0d draws, sprite %h, expected 1 draw of F0 at cycle 3",
                     drw_cyc.size(), sprs.size() ? sprs[0] : 8'hxx);
        end
        n_assert++;
        if (done_cyc != 5 || vf_done !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_done: got cycle %0d vf %b, expected cycle 5 vf 0", done_cyc, vf_done);
        end
        n_assert++;
        if (busy_drop != 6) begin
            n_fail++; $display("FAIL basic_busy: got idle at %0d expected 6", busy_drop);
        end
    endtask

    task automatic test_collision();
        run(1'b0, 1'b1, 8'd0, 8'd0, 4'd1, 12'h050, 0, 1'b0);
        n_assert++;
        if (done_cyc != 5 || vf_done !== 1'b1) begin
            n_fail++;
            $display("FAIL collision_vf: got cycle %0d vf %b, expected cycle 5 vf 1", done_cyc, vf_done);
        end
        @(negedge clk);
        n_assert++;
        if (vf !== 1'b1) begin
            n_fail++; $display("FAIL collision_vf_hold: got %b expected 1", vf);
        end
    endtask

    task automatic test_n_zero();
        run(1'b0, 1'b1, 8'd3, 8'd3, 4'd0, 12'h050, 0, 1'b0);
        n_assert++;
        if (done_cyc != 1 || vf_done !== 1'b0 || rd_cyc.size() != 0 || drw_cyc.size() != 0) begin
            n_fail++;
            $display("FAIL n_zero: got done %0d vf %b reads %0d draws %0d, expected 1 0 0 0",
                     done_cyc, vf_done, rd_cyc.size(), drw_cyc.size());
        end
    endtask

    task automatic test_wrap();
        int nr;
        logic [11:0] ea;
        nr = CLIP ? 2 : 5;
        run(1'b0, 1'b1, 8'd8, 8'd30, 4'd5, 12'hFFE, 0, 1'b0);
        n_assert++;
        if (rd_cyc.size() != nr || drw_cyc.size() != nr) begin
            n_fail++;
            $display("FAIL wrap_rows: got %0d reads %0d draws expected %0d",
                     rd_cyc.size(), drw_cyc.size(), nr);
        end else begin
            for (int r = 0; r < nr; r++) begin
                ea = 12'hFFE + 12'(r);
                n_assert++;
                if (rd_cyc[r] != 4*r+1 || addrs[r] !== ea) begin
                    n_fail++;
                    $display("FAIL wrap_addr%0d: got %h at %0d expected %h at %0d",
                             r, addrs[r], rd_cyc[r], ea, 4*r+1);
                end
                n_assert++;
                if (drw_cyc[r] != 4*r+3 || rws[r] !== 4'(r) || sprs[r] !== mem[ea]) begin
                    n_fail++;
                    $display("FAIL wrap_draw%0d: got row %0d sprite %h at %0d expected row %0d sprite %h at %0d",
                             r, rws[r], sprs[r], drw_cyc[r], r, mem[ea], 4*r+3);
                end
            end
        end
        n_assert++;
        if (done_cyc != 4*nr+1 || vf_done !== 1'b0) begin
            n_fail++;
            $display("FAIL wrap_done: got cycle %0d vf %b expected cycle %0d vf 0",
                     done_cyc, vf_done, 4*nr+1);
        end
    endtask

    task automatic test_clip_x();
        logic [7:0] es;
        es = CLIP ? 8'hF0 : 8'hFF;
        for (int k = 0; k < 2; k++) begin
            run(1'b0, 1'b1, 8'h7C, 8'd0, 4'd1, 12'h100, 0, 1'b0);
            n_assert++;
            if (sprs.size() != 1 || sprs[0] !== es || dxs[0] !== 6'd60) begin
                n_fail++;
                $display("FAIL clip_x%0d: got %0d draws sprite %h x %0d expected sprite %h x 60",
                         k, sprs.size(), sprs.size() ? sprs[0] : 8'hxx,
                         dxs.size() ? dxs[0] : 6'hxx, es);
            end
            n_assert++;
            if (done_cyc != 5 || vf_done !== 1'(k)) begin
                n_fail++;
                $display("FAIL clip_x_vf%0d: got cycle %0d vf %b expected cycle 5 vf %0d",
                         k, done_cyc, vf_done, k);
            end
        end
    endtask

    task automatic test_cls();
        run(1'b1, 1'b1, 8'd0, 8'd0, 4'd1, 12'h050, 0, 1'b1);
        n_assert++;
        if (clr_cyc != 1 || rd_cyc.size() != 0 || drw_cyc.size() != 0) begin
            n_fail++;
            $display("FAIL cls_clear: got clear %0d reads %0d draws %0d expected 1 0 0",
                     clr_cyc, rd_cyc.size(), drw_cyc.size());
        end
        n_assert++;
        if (done_cyc != 2 || vf_done !== 1'b0 || busy_drop != 3) begin
            n_fail++;
            $display("FAIL cls_done: got done %0d vf %b idle %0d expected 2 0 3",
                     done_cyc, vf_done, busy_drop);
        end
        repeat (4) begin
            @(negedge clk);
            n_assert++;
            if (busy !== 1'b0 || mem_rd !== 1'b0) begin
                n_fail++;
                $display("FAIL cls_start_ignored: got busy %b mem_rd %b expected 0 0", busy, mem_rd);
            end
        end
    endtask

    task automatic test_reset_mid();
        run(1'b0, 1'b1, 8'd0, 8'd10, 4'd4, 12'h200, 11, 1'b0);
        n_assert++;
        if (drw_cyc.size() != 3 || rws[2] !== 4'd2 || drw_cyc[2] != 11) begin
            n_fail++;
            $display("FAIL abort_rows: got %0d draws expected 3 ending row 2 at cycle 11", drw_cyc.size());
        end
        n_assert++;
        if (busy_drop != 12 || zero_ok !== 1'b1 || done_cyc != -1) begin
            n_fail++;
            $display("FAIL abort_state: got idle %0d zero %b done %0d expected 12 1 -1",
                     busy_drop, zero_ok, done_cyc);
        end
        repeat (3) begin
            @(negedge clk);
            n_assert++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                n_fail++; $display("FAIL abort_no_done: got done %b busy %b expected 0 0", done, busy);
            end
        end
        run(1'b0, 1'b1, 8'd20, 8'd20, 4'd1, 12'h050, 0, 1'b0);
        n_assert++;
        if (done_cyc != 5 || vf_done !== 1'b0 || addrs.size() != 1 || addrs[0] !== 12'h050) begin
            n_fail++;
            $display("FAIL abort_recover: got done %0d vf %b reads %0d expected 5 0 1",
                     done_cyc, vf_done, addrs.size());
        end
    endtask

    initial begin
        for (int a = 0; a < 4096; a++) mem[a] = 8'h00;
        for (int r = 0; r < 32; r++) fb[r] = '0;
        mem[12'h050] = 8'hF0;
        mem[12'h100] = 8'hFF;
        mem[12'hFFE] = 8'h11;
        mem[12'hFFF] = 8'h22;
        mem[12'h000] = 8'h33;
        mem[12'h001] = 8'h44;
        mem[12'h002] = 8'h55;
        for (int a = 0; a < 4; a++) mem[12'h200 + a] = 8'(8'h81 + a);
        mem_data = 8'h00;
        disp_collision = 1'b0;
        test_reset();
        test_basic_draw();
        test_collision();
        test_n_zero();
        test_wrap();
        test_clip_x();
        test_cls();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
